// File: rtl/alu_share_arb_if.sv
// Bundle between two requesters, the arbiter and the shared external ALU.
// slave = arbiter side, master = requesters plus the combinational ALU.
interface alu_share_arb_if #(
    parameter int WIDTH = 32
);
    logic             r0_req,    r1_req;
    logic [WIDTH-1:0] r0_a,      r0_b,      r1_a,      r1_b;
    logic [2:0]       r0_ctrl,   r1_ctrl;
    logic             r0_sral,   r1_sral;
    logic             r0_ready,  r1_ready;
    logic             r0_valid,  r1_valid;
    logic [WIDTH-1:0] r0_result, r1_result;
    logic             r0_zero,   r1_zero;
    logic             flush0;
    logic [WIDTH-1:0] alu_a,     alu_b;
    logic [2:0]       alu_ctrl;
    logic             alu_sral;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             busy;

    modport slave (
        input  r0_req, r1_req, r0_a, r0_b, r1_a, r1_b,
        input  r0_ctrl, r1_ctrl, r0_sral, r1_sral, flush0,
        input  alu_out, alu_zero,
        output r0_ready, r1_ready, r0_valid, r1_valid,
        output r0_result, r1_result, r0_zero, r1_zero,
        output alu_a, alu_b, alu_ctrl, alu_sral, busy
    );

    modport master (
        output r0_req, r1_req, r0_a, r0_b, r1_a, r1_b,
        output r0_ctrl, r1_ctrl, r0_sral, r1_sral, flush0,
        output alu_out, alu_zero,
        input  r0_ready, r1_ready, r0_valid, r1_valid,
        input  r0_result, r1_result, r0_zero, r1_zero,
        input  alu_a, alu_b, alu_ctrl, alu_sral, busy
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin share of one external ALU between two ports: accept, execute, respond (2-cycle latency).
// Requests wait (ready low) while the other port holds the grant; responses have no backpressure.
module alu_share_arb #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_share_arb_if.slave bus
);
    logic             last_q,   last_d;
    logic             s1_vld_q, s1_vld_d;
    logic             s1_id_q,  s1_id_d;
    logic [WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [WIDTH-1:0] s1_b_q,   s1_b_d;
    logic [2:0]       s1_ctrl_q, s1_ctrl_d;
    logic             s1_sral_q, s1_sral_d;
    logic             s2_vld_q, s2_vld_d;
    logic             s2_id_q,  s2_id_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_zero_q, s2_zero_d;
    logic [WIDTH-1:0] hold0_res_q, hold0_res_d, hold1_res_q, hold1_res_d;
    logic             hold0_zero_q, hold0_zero_d, hold1_zero_q, hold1_zero_d;
    logic             grant0, grant1, vld0, vld1, s1_live;

    // last_q == 1 means port 1 was served last, so port 0 wins a tie.
    assign grant0 = bus.r0_req & (~bus.r1_req |  last_q);
    assign grant1 = bus.r1_req & (~bus.r0_req | ~last_q);

    assign vld0    = s2_vld_q & ~s2_id_q & ~bus.flush0 & ~reset;
    assign vld1    = s2_vld_q &  s2_id_q & ~reset;
    assign s1_live = s1_vld_q & ~reset;

    always_comb begin
        last_d       = last_q;
        s1_vld_d     = (grant0 & ~bus.flush0) | grant1;
        s1_id_d      = grant1;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_ctrl_d    = s1_ctrl_q;
        s1_sral_d    = s1_sral_q;
        s2_vld_d     = s1_vld_q & ~(bus.flush0 & ~s1_id_q);
        s2_id_d      = s1_id_q;
        s2_res_d     = s2_res_q;
        s2_zero_d    = s2_zero_q;
        hold0_res_d  = vld0 ? s2_res_q  : hold0_res_q;
        hold0_zero_d = vld0 ? s2_zero_q : hold0_zero_q;
        hold1_res_d  = vld1 ? s2_res_q  : hold1_res_q;
        hold1_zero_d = vld1 ? s2_zero_q : hold1_zero_q;
        if (grant0) begin
            last_d    = 1'b0;
            s1_a_d    = bus.r0_a;
            s1_b_d    = bus.r0_b;
            s1_ctrl_d = bus.r0_ctrl;
            s1_sral_d = bus.r0_sral;
        end else if (grant1) begin
            last_d    = 1'b1;
            s1_a_d    = bus.r1_a;
            s1_b_d    = bus.r1_b;
            s1_ctrl_d = bus.r1_ctrl;
            s1_sral_d = bus.r1_sral;
        end
        if (s1_vld_q) begin
            s2_res_d  = bus.alu_out;
            s2_zero_d = bus.alu_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q       <= 1'b1;
            s1_vld_q     <= 1'b0;
            s1_id_q      <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_ctrl_q    <= '0;
            s1_sral_q    <= 1'b0;
            s2_vld_q     <= 1'b0;
            s2_id_q      <= 1'b0;
            s2_res_q     <= '0;
            s2_zero_q    <= 1'b0;
            hold0_res_q  <= '0;
            hold0_zero_q <= 1'b0;
            hold1_res_q  <= '0;
            hold1_zero_q <= 1'b0;
        end else begin
            last_q       <= last_d;
            s1_vld_q     <= s1_vld_d;
            s1_id_q      <= s1_id_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_ctrl_q    <= s1_ctrl_d;
            s1_sral_q    <= s1_sral_d;
            s2_vld_q     <= s2_vld_d;
            s2_id_q      <= s2_id_d;
            s2_res_q     <= s2_res_d;
            s2_zero_q    <= s2_zero_d;
            hold0_res_q  <= hold0_res_d;
            hold0_zero_q <= hold0_zero_d;
            hold1_res_q  <= hold1_res_d;
            hold1_zero_q <= hold1_zero_d;
        end
    end

    assign bus.r0_ready  = grant0 & ~reset;
    assign bus.r1_ready  = grant1 & ~reset;
    assign bus.r0_valid  = vld0;
    assign bus.r1_valid  = vld1;
    assign bus.r0_result = vld0 ? s2_res_q  : hold0_res_q;
    assign bus.r0_zero   = vld0 ? s2_zero_q : hold0_zero_q;
    assign bus.r1_result = vld1 ? s2_res_q  : hold1_res_q;
    assign bus.r1_zero   = vld1 ? s2_zero_q : hold1_zero_q;
    assign bus.alu_a     = s1_live ? s1_a_q    : '0;
    assign bus.alu_b     = s1_live ? s1_b_q    : '0;
    assign bus.alu_ctrl  = s1_live ? s1_ctrl_q : '0;
    assign bus.alu_sral  = s1_live & s1_sral_q;
    assign bus.busy      = (s1_vld_q | s2_vld_q) & ~reset;
endmodule
